// File: rtl/fifo_uart_tx.sv
// Drains bytes from the 4x8 FIFO read port and sends each as a UART frame:
// start bit, 8 data bits LSB first, optional parity bit, then one or two stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          rd_en_q, rd_en_d;
  logic          done_q, done_d;
  logic          baud_last;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    baud_last = (baud_q == BAUD_MAX);

    // The baud counter only runs while a bit is on the line.
    if (state_q == S_START || state_q == S_DATA ||
        state_q == S_PARITY || state_q == S_STOP) begin
      baud_d = baud_last ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_enable && !fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        shift_d  = fifo_data;
        parity_d = (PARITY_ODD != 0) ? ~^fifo_data : ^fifo_data;
        state_d  = S_START;
      end
      S_START: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (baud_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) state_d = S_IDLE;
          else                    bit_d   = bit_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    rd_en_d = (state_d == S_FETCH);
    done_d  = (state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  // Byte and parity are reloaded in WAIT before use, so they need no reset.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (no parity, even parity with
// two stop bits, odd parity) at 4 clocks per bit, checked cycle by cycle.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_enable = 1'b1;

  logic       fifo_empty0 = 1'b1, fifo_empty1 = 1'b1, fifo_empty2 = 1'b1;
  logic [7:0] fifo_data0 = 8'h00, fifo_data1 = 8'h00, fifo_data2 = 8'h00;
  logic       rd0, rd1, rd2, tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int underflow = 0;
  logic [7:0] fq[$];
  logic [7:0] pb = 8'h00;
  logic       pend = 1'b0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty0),
    .fifo_data(fifo_data0), .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(done0));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty1),
    .fifo_data(fifo_data1), .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(done1));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty2),
    .fifo_data(fifo_data2), .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .frame_done(done2));

  typedef struct {
    int          w;
    logic [7:0]  d;
    logic [11:0] exp;
    int          nbits;
  } vec_t;

  vec_t tbl[7];

  function automatic logic txo(input int w);
    return (w == 1) ? tx1 : (w == 2) ? tx2 : tx0;
  endfunction
  function automatic logic rdo(input int w);
    return (w == 1) ? rd1 : (w == 2) ? rd2 : rd0;
  endfunction
  function automatic logic bzo(input int w);
    return (w == 1) ? busy1 : (w == 2) ? busy2 : busy0;
  endfunction
  function automatic logic fdo(input int w);
    return (w == 1) ? done1 : (w == 2) ? done2 : done0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Advance to the next falling edge; the FIFO model pops on a pop request
  // and presents the byte on fifo_data during the following cycle.
  task automatic cycle();
    @(negedge clk);
    if (rd0) begin
      if (fq.size() > 0) begin
        pb   = fq.pop_front();
        pend = 1'b1;
        pops++;
      end else begin
        underflow++;
      end
    end else if (pend) begin
      fifo_data0 = pb;
      pend       = 1'b0;
    end
    fifo_empty0 = (fq.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty0 = 1'b0;
  endtask

  task automatic idle_chk(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      chk({name, "_rd"}, int'(rd0), 0);
      chk({name, "_busy"}, int'(busy0), 0);
    end
  endtask

  // Called at a falling edge with the DUT in IDLE and a byte available.
  task automatic frame(input int w, input logic [7:0] d, input logic [11:0] exp,
                       input int nbits, input int drop_at);
    if (w == 1) begin fifo_data1 = d; fifo_empty1 = 1'b0; end
    if (w == 2) begin fifo_data2 = d; fifo_empty2 = 1'b0; end
    cycle();
    chk("fetch_rd", int'(rdo(w)), 1);
    chk("fetch_busy", int'(bzo(w)), 1);
    chk("fetch_tx", int'(txo(w)), 1);
    if (w == 1) fifo_empty1 = 1'b1;
    if (w == 2) fifo_empty2 = 1'b1;
    cycle();
    chk("wait_rd", int'(rdo(w)), 0);
    chk("wait_busy", int'(bzo(w)), 1);
    chk("wait_tx", int'(txo(w)), 1);
    for (int i = 0; i < nbits * 4; i++) begin
      cycle();
      chk("tx_bit", int'(txo(w)), int'(exp[i / 4]));
      chk("frame_done", int'(fdo(w)), int'(i == nbits * 4 - 1));
      chk("frame_busy", int'(bzo(w)), 1);
      chk("frame_rd", int'(rdo(w)), 0);
      if (i == drop_at) tx_enable = 1'b0;
    end
    cycle();
    chk("end_busy", int'(bzo(w)), 0);
    chk("end_tx", int'(txo(w)), 1);
    chk("end_done", int'(fdo(w)), 0);
    chk("end_rd", int'(rdo(w)), 0);
  endtask

  initial begin
    // Frame bits listed last-sent first: {pad/stop, stop, parity/stop, data, start}.
    tbl[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
    tbl[1] = '{0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
    tbl[2] = '{0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};
    tbl[3] = '{1, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12};
    tbl[4] = '{1, 8'h03, {1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 12};
    tbl[5] = '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11};
    tbl[6] = '{2, 8'h03, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11};

    // Reset values, then release with every FIFO empty.
    cycle();
    cycle();
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_rd", int'(rd0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_tx1", int'(tx1), 1);
    chk("rst_tx2", int'(tx2), 1);
    rst_n = 1'b1;
    idle_chk("empty", 5);

    // Single frames from the vector table.
    for (int k = 0; k < 7; k++) begin
      if (tbl[k].w == 0) push(tbl[k].d);
      frame(tbl[k].w, tbl[k].d, tbl[k].exp, tbl[k].nbits, -1);
    end
    chk("pops_single", pops, 3);

    // Full FIFO drained back to back, in order.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    frame(0, 8'h11, {2'b00, 1'b1, 8'h11, 1'b0}, 10, -1);
    frame(0, 8'h22, {2'b00, 1'b1, 8'h22, 1'b0}, 10, -1);
    frame(0, 8'h33, {2'b00, 1'b1, 8'h33, 1'b0}, 10, -1);
    frame(0, 8'h44, {2'b00, 1'b1, 8'h44, 1'b0}, 10, -1);
    chk("pops_burst", pops, 7);
    idle_chk("drained", 6);

    // Disabled with data queued, then enable dropped mid-DATA.
    tx_enable = 1'b0;
    push(8'h3C); push(8'h96);
    idle_chk("disabled", 8);
    tx_enable = 1'b1;
    frame(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 12);
    chk("enable_dropped", int'(tx_enable), 0);
    idle_chk("held", 8);
    chk("pops_held", pops, 8);
    tx_enable = 1'b1;
    frame(0, 8'h96, {2'b00, 1'b1, 8'h96, 1'b0}, 10, -1);

    // Reset in the middle of DATA discards the popped byte.
    push(8'h5A); push(8'hC3);
    for (int i = 0; i < 12; i++) cycle();
    chk("mid_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx0), 1);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_rd", int'(rd0), 0);
    cycle();
    rst_n = 1'b1;
    frame(0, 8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, -1);
    chk("pops_final", pops, 11);
    idle_chk("final", 4);
    chk("no_underflow", underflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
